imem_fetch_responder: RTL

//  Instruction-memory responder: the far end of the fetch interface driven by the program counter.

---
 rtl/imem_fetch_responder_pkg.sv | 16 +
 rtl/imem_fetch_responder_array.sv | 35 +++
 rtl/imem_fetch_responder.sv | 125 ++++++++++++
 3 files changed

// File: rtl/imem_fetch_responder_pkg.sv
// Shared types and constants for the instruction-memory fetch responder.
//   XLEN      : instruction word width
//   NOP_INSTR : instruction returned for faulting fetches (addi x0,x0,0)
//   state_t   : responder FSM states
package imem_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/imem_fetch_responder_array.sv
// Instruction ROM: DEPTH_WORDS x XLEN words with a registered (synchronous) read port.
//   clk       : clock, rising edge
//   rst       : asynchronous active-low reset (clears the read register only)
//   i_rd_en   : capture mem[i_rd_idx] on this edge
//   i_rd_idx  : word index to read
//   o_rd_data : last word read; holds until the next read
module imem_array
  import imem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned IDX_W       = 10,
  parameter string       INIT_FILE   = ""
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_rd_en,
  input  logic [IDX_W-1:0] i_rd_idx,
  output logic [XLEN-1:0]  o_rd_data
);

  logic [XLEN-1:0] r_mem [DEPTH_WORDS];
  logic [XLEN-1:0] r_rd_data;

  // Synchronous read; the caller guarantees i_rd_idx is in range when i_rd_en is high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_data <= '0;
    end else if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_idx];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/imem_fetch_responder.sv
// Instruction-memory responder at the far end of the fetch interface.
// One fetch outstanding at a time; the response appears LATENCY cycles after the
// accept cycle and is held until consumed. Misaligned or out-of-range fetches return
// NOP with rsp_err set. flush drops any in-flight fetch without a response.
//   clk, rst              : clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready   : request handshake, req_addr is the byte address
//   flush                 : discard in-flight fetch; blocks acceptance this cycle
//   rsp_valid/rsp_ready   : response handshake
//   rsp_instr/addr/err    : instruction word, its address, fault flag
module imem_fetch_responder
  import imem_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2,
  parameter string       INIT_FILE   = ""
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              flush,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [XLEN-1:0]   rsp_instr,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic              rsp_err
);

  localparam int unsigned IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned CNT_W    = 4;
  localparam int unsigned CNT_INIT = (LATENCY >= 2) ? (LATENCY - 2) : 0;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [ADDR_W-1:0]   r_req_addr;
  logic [ADDR_W-1:0]   r_rsp_addr;
  logic                r_rsp_err;

  logic                w_accept;
  logic                w_load;
  logic [ADDR_W-1:0]   w_src_addr;
  logic [ADDR_W-3:0]   w_src_idx;
  logic                w_src_err;
  logic                w_rd_en;
  logic [IDX_W-1:0]    w_rd_idx;
  logic [XLEN-1:0]     w_rd_data;

  // Handshake: flush always blocks acceptance; a held response must be consumed first.
  assign req_ready = !flush && ((r_state == IDLE) || ((r_state == RESP) && rsp_ready));
  assign w_accept  = req_valid && req_ready;

  // This edge enters RESP: either a single-cycle fetch is accepted or the wait ran out.
  assign w_load = !flush &&
                  ((w_accept && (LATENCY == 1)) || ((r_state == WAIT) && (r_cnt == '0)));

  // In WAIT the fetch address is the latched one; otherwise it is the one being accepted.
  assign w_src_addr = (r_state == WAIT) ? r_req_addr : req_addr;
  assign w_src_idx  = w_src_addr[ADDR_W-1:2];
  assign w_src_err  = (w_src_addr[1:0] != 2'b00) ||
                      (64'(w_src_idx) >= 64'(DEPTH_WORDS));

  // Faulting fetches never touch the array, so no index wrap can occur.
  assign w_rd_en  = w_load && !w_src_err;
  assign w_rd_idx = IDX_W'(w_src_idx);

  imem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W),
    .INIT_FILE   (INIT_FILE)
  ) u_array (
    .clk       (clk),
    .rst       (rst),
    .i_rd_en   (w_rd_en),
    .i_rd_idx  (w_rd_idx),
    .o_rd_data (w_rd_data)
  );

  // FSM, latency counter and response registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_req_addr <= '0;
      r_rsp_addr <= '0;
      r_rsp_err  <= 1'b0;
    end else begin
      if (w_load) begin
        r_rsp_addr <= w_src_addr;
        r_rsp_err  <= w_src_err;
      end

      if (w_accept) begin
        r_req_addr <= req_addr;
        r_cnt      <= CNT_W'(CNT_INIT);
      end else if ((r_state == WAIT) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end

      case (r_state)
        IDLE: begin
          if (w_accept) r_state <= (LATENCY == 1) ? RESP : WAIT;
        end
        WAIT: begin
          if (flush)              r_state <= IDLE;
          else if (r_cnt == '0)   r_state <= RESP;
        end
        RESP: begin
          if (flush)              r_state <= IDLE;
          else if (w_accept)      r_state <= (LATENCY == 1) ? RESP : WAIT;
          else if (rsp_ready)     r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign rsp_valid = (r_state == RESP);
  assign rsp_addr  = r_rsp_addr;
  assign rsp_err   = r_rsp_err;
  // Both mux inputs are registers; the stale array word is masked on a fault.
  assign rsp_instr = r_rsp_err ? NOP_INSTR : w_rd_data;

endmodule
